// File: rtl/vreg_read_arbiter_pkg.sv
// Shared types and constants for the vector register read arbiter.
// Holds the FSM states, group-size encodings and the request legality check.
package vreg_read_arbiter_pkg;

  localparam int NUM_VREGS = 32;
  localparam int SEL_W     = $clog2(NUM_VREGS);

  localparam logic [2:0] VLMUL_1 = 3'd0;
  localparam logic [2:0] VLMUL_2 = 3'd1;
  localparam logic [2:0] VLMUL_4 = 3'd2;
  localparam logic [2:0] VLMUL_8 = 3'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_e;

  // A group must start on a multiple of its size; encodings above 8 regs are illegal.
  function automatic logic is_illegal(input logic [SEL_W-1:0] sel, input logic [2:0] vlmul);
    logic bad;
    case (vlmul)
      VLMUL_1: bad = 1'b0;
      VLMUL_2: bad = sel[0];
      VLMUL_4: bad = |sel[1:0];
      VLMUL_8: bad = |sel[2:0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/vreg_read_arbiter_rr_arb2.sv
// Two-way round-robin grant: i_ptr names the requester that wins a conflict.
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_ptr,
  output logic [1:0] o_grant
);

  // One-hot grant; a lone requester always wins regardless of the pointer.
  always_comb begin
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_ptr ? 2'b10 : 2'b01;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/vreg_read_arbiter.sv
// Arbitrates two requesters onto one grouped vector-register read port.
// One request in flight at a time: grant, drive the mux for a cycle, then hold the response.
module vreg_read_arbiter
  import vreg_read_arbiter_pkg::*;
#(
  parameter int   DATA_W  = 256,
  parameter logic RR_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic [2:0]        req0_vlmul,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [SEL_W-1:0]  req1_sel,
  input  logic [2:0]        req1_vlmul,
  output logic [SEL_W-1:0]  mux_sel,
  output logic [2:0]        mux_vlmul,
  input  logic [DATA_W-1:0] mux_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  state_e            r_state;
  state_e            w_next_state;
  logic              r_ptr;
  logic [SEL_W-1:0]  r_sel;
  logic [2:0]        r_vlmul;
  logic              r_id;
  logic [DATA_W-1:0] r_data;
  logic              r_err;
  logic [1:0]        w_grant;
  logic              w_take;
  logic              w_illegal;

  rr_arb2 u_arb (
    .i_valid ({req1_valid, req0_valid}),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  assign w_take    = (r_state == IDLE) && (|w_grant);
  assign w_illegal = is_illegal(r_sel, r_vlmul);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (|w_grant) w_next_state = READ;
        else          w_next_state = IDLE;
      end
      READ: w_next_state = RESP;
      RESP: begin
        if (rsp_ready) w_next_state = IDLE;
        else           w_next_state = RESP;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Output decode; readies stay low while reset is asserted
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = (r_state == RESP);
    if (rst_n && (r_state == IDLE)) begin
      req0_ready = w_grant[0];
      req1_ready = w_grant[1];
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  // Request latch doubles as the mux drive, so it naturally holds outside READ
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr   <= RR_INIT;
      r_sel   <= '0;
      r_vlmul <= 3'd0;
      r_id    <= 1'b0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_take) begin
        r_sel   <= w_grant[1] ? req1_sel : req0_sel;
        r_vlmul <= w_grant[1] ? req1_vlmul : req0_vlmul;
        r_id    <= w_grant[1];
        r_ptr   <= ~w_grant[1];
      end
      if (r_state == READ) begin
        r_data <= w_illegal ? '0 : mux_data;
        r_err  <= w_illegal;
      end
    end
  end

  assign mux_sel   = r_sel;
  assign mux_vlmul = r_vlmul;
  assign rsp_id    = r_id;
  assign rsp_data  = r_data;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_vreg_read_arbiter.sv
// Self-checking bench for vreg_read_arbiter: vector table, hand sequences, random traffic.
module tb_vreg_read_arbiter;

  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [4:0]    req0_sel, req1_sel, mux_sel;
  logic [2:0]    req0_vlmul, req1_vlmul, mux_vlmul;
  logic [DW-1:0] mux_data, rsp_data;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0]   regs [32];

  int total = 0;
  int bad   = 0;
  int mptr  = 0;
  int cyc   = 0;

  typedef struct {
    bit v0; bit v1;
    int s0; int l0; int s1; int l1;
    int exp_id; bit exp_err;
  } vec_t;
  vec_t vecs [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vreg_read_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_sel   (req0_sel),
    .req0_vlmul (req0_vlmul),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_sel   (req1_sel),
    .req1_vlmul (req1_vlmul),
    .mux_sel    (mux_sel),
    .mux_vlmul  (mux_vlmul),
    .mux_data   (mux_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
  );

  // Register-file mux model: group words in ascending order, upper words zero.
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < 8; i++)
      if ((mux_vlmul > 3'd3) || (i < (1 << mux_vlmul)))
        mux_data[i*32 +: 32] = regs[(int'(mux_sel) + i) % 32];
  end

  function automatic bit ref_illegal(input int sel, input int lmul);
    return (lmul > 3) || ((sel % (1 << lmul)) != 0);
  endfunction

  function automatic logic [DW-1:0] ref_data(input int sel, input int lmul);
    logic [DW-1:0] d;
    d = '0;
    if (!ref_illegal(sel, lmul))
      for (int i = 0; i < (1 << lmul); i++) d[i*32 +: 32] = regs[(sel + i) % 32];
    return d;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, mux_sel, mux_vlmul}, '0);
    chk({nm, "_data"}, rsp_data, '0);
  endtask

  // Issue a request set, check grant, mux drive, response and optional backpressure.
  task automatic run_txn(input bit v0, input bit v1, input int s0, input int l0,
                         input int s1, input int l1, input int exp_id, input bit exp_err,
                         input int hold, input bit keep, output int gcyc);
    bit got;
    int s, l;
    logic [DW-1:0] exp_d;
    got = 1'b0;
    gcyc = -1;
    req0_valid = v0; req1_valid = v1;
    req0_sel = 5'(s0); req0_vlmul = 3'(l0);
    req1_sel = 5'(s1); req1_vlmul = 3'(l1);
    rsp_ready = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("grant_seen", got, 1);
    if (!got) begin
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    gcyc = cyc;
    chk("grant_id", {req1_ready, req0_ready}, (exp_id == 1) ? 2'b10 : 2'b01);
    chk("rsp_valid_at_grant", rsp_valid, 0);
    s = exp_id ? s1 : s0;
    l = exp_id ? l1 : l0;
    exp_d = ref_data(s, l);
    mptr = 1 - exp_id;
    @(posedge clk); #1;
    if (!keep) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    @(negedge clk);
    chk("mux_sel", mux_sel, s);
    chk("mux_vlmul", mux_vlmul, l);
    chk("ready_in_read", {req1_ready, req0_ready}, 0);
    chk("rsp_valid_in_read", rsp_valid, 0);
    @(posedge clk); #1;
    rsp_ready = (hold == 0);
    @(negedge clk);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, exp_id);
    chk("rsp_err", rsp_err, exp_err);
    chk("rsp_data", rsp_data, exp_d);
    chk("ready_in_resp", {req1_ready, req0_ready}, 0);
    for (int h = 1; h <= hold; h++) begin
      @(posedge clk); #1;
      rsp_ready = (h == hold);
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, exp_d);
      chk("hold_id", rsp_id, exp_id);
      chk("hold_err", rsp_err, exp_err);
      chk("hold_ready", {req1_ready, req0_ready}, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end in time");
    $fatal(1);
  end

  initial begin
    int g, gprev, v0, v1, s0, s1, l0, l1, e, h;
    bit got;
    for (int k = 0; k < 32; k++) regs[k] = 32'(k);
    regs[31] = 32'hDEADBEEF;
    vecs[0] = '{1, 0,  8, 3,  0, 0, 0, 0};
    vecs[1] = '{0, 1,  0, 0,  5, 2, 1, 1};
    vecs[2] = '{0, 1,  0, 0,  4, 5, 1, 1};
    vecs[3] = '{1, 0, 31, 0,  0, 0, 0, 0};
    vecs[4] = '{1, 1,  0, 1, 16, 2, 1, 0};
    vecs[5] = '{1, 1,  2, 1,  3, 0, 0, 0};
    vecs[6] = '{1, 0,  4, 2,  0, 0, 0, 0};
    vecs[7] = '{1, 1,  6, 3, 24, 3, 1, 0};

    // Reset with a requester already valid: nothing may be granted.
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_sel = 5'd0; req0_vlmul = 3'd0; req1_sel = 5'd0; req1_vlmul = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1; req0_valid = 1'b0;
    mptr = 0;

    for (int i = 0; i < 8; i++)
      run_txn(vecs[i].v0, vecs[i].v1, vecs[i].s0, vecs[i].l0, vecs[i].s1, vecs[i].l1,
              vecs[i].exp_id, vecs[i].exp_err, (i == 4) ? 1 : 0, 1'b0, g);

    // Both held valid: grants alternate every 3 cycles.
    gprev = 0;
    for (int i = 0; i < 4; i++) begin
      run_txn(1, 1, 0, 1, 8, 3, mptr, 0, 0, 1'b1, g);
      chk("alt_expected_id", mptr, (i % 2 == 0) ? 1 : 0);
      if (i > 0) chk("alt_gap", g - gprev, 3);
      gprev = g;
    end

    // Backpressure: 4 stalled cycles delay the next grant by exactly 4.
    run_txn(1, 1, 0, 1, 8, 3, mptr, 0, 4, 1'b1, gprev);
    run_txn(1, 1, 0, 1, 8, 3, mptr, 0, 0, 1'b1, g);
    chk("bp_gap", g - gprev, 7);

    // Reset while READ: request dropped, pointer back to its initial value.
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_sel = 5'd8; req0_vlmul = 3'd3;
    got = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (req0_ready) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("rst_grant_seen", got, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mux_sel_in_read", mux_sel, 8);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("rst_mid_read");
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("no_rsp_after_rst", rsp_valid, 0);
    end
    @(posedge clk); #1;
    mptr = 0;
    run_txn(1, 1, 0, 0, 1, 0, 0, 0, 0, 1'b0, g);

    // Random traffic against the reference model.
    for (int k = 0; k < 32; k++) regs[k] = $urandom;
    for (int n = 0; n < 40; n++) begin
      v0 = $urandom_range(0, 1);
      v1 = $urandom_range(0, 1);
      if (v0 == 0 && v1 == 0) v0 = 1;
      l0 = $urandom_range(0, 5);
      l1 = $urandom_range(0, 5);
      s0 = $urandom_range(0, 31);
      s1 = $urandom_range(0, 31);
      if ($urandom_range(0, 2) != 0 && l0 <= 3) s0 = s0 & ~((1 << l0) - 1);
      if ($urandom_range(0, 2) != 0 && l1 <= 3) s1 = s1 & ~((1 << l1) - 1);
      e = (v0 != 0 && v1 != 0) ? mptr : ((v1 != 0) ? 1 : 0);
      h = $urandom_range(0, 2);
      run_txn(v0 != 0, v1 != 0, s0, l0, s1, l1, e,
              ref_illegal(e ? s1 : s0, e ? l1 : l0), h, 1'b0, g);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vreg_read_arbiter.md
VREG_READ_ARBITER -- requirements
Module: vreg_read_arbiter

Interface
REQ-001 Parameter DATA_W, default 256: width of the grouped register read data (8 x 32-bit registers).
REQ-002 Parameter RR_INIT, default 0: requester given priority first after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 req0_valid / req1_valid  input  1  requester n has a read pending.
REQ-006 req0_ready / req1_ready  output  1  requester n accepted this cycle.
REQ-007 req0_sel / req1_sel  input  5  base register index r0..r31.
REQ-008 req0_vlmul / req1_vlmul  input  3  group size: 0=1 reg, 1=2, 2=4, 3=8; 4..7 illegal.
REQ-009 mux_sel  output  5  register index driven to the grouped register output mux.
REQ-010 mux_vlmul  output  3  group size driven to the mux.
REQ-011 mux_data  input  DATA_W  combinational mux result, zero-extended for groups smaller than 8.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  consumer accepts the response.
REQ-014 rsp_id  output  1  requester that owns the response.
REQ-015 rsp_data  output  DATA_W  registered read data.
REQ-016 rsp_err  output  1  request was illegal; rsp_data is 0.

Function
REQ-017 FSM states SHALL be IDLE, READ and RESP.
REQ-018 IDLE: if any reqN_valid is high, grant exactly one requester, pulse its ready for one cycle, latch sel/vlmul/id, and go to READ.
REQ-019 Arbitration SHALL be round-robin: on conflict, grant the requester not granted last; a lone valid requester is always granted.
REQ-020 The round-robin pointer SHALL update only when a grant occurs.
REQ-021 reqN_ready SHALL be low in READ and RESP; requests held valid wait without loss.
REQ-022 READ: mux_sel and mux_vlmul SHALL equal the latched values; rsp_data <= mux_data; go to RESP.
REQ-023 Outside READ, mux_sel and mux_vlmul SHALL hold their last value (0 after reset).
REQ-024 Illegal request: vlmul > 3, or sel not aligned to the group size (sel[0] != 0 for 2, sel[1:0] != 0 for 4, sel[2:0] != 0 for 8).
REQ-025 Illegal requests SHALL still pass through READ; rsp_data SHALL be captured as 0 and rsp_err set to 1.
REQ-026 RESP: rsp_valid = 1; rsp_id/rsp_data/rsp_err stable until rsp_ready is high, then go to IDLE.
REQ-027 Latency: ready pulse in cycle T gives rsp_valid in T+2; minimum issue interval is 3 cycles.
REQ-028 The next grant SHALL NOT occur in the cycle rsp_ready is sampled; it occurs in IDLE the following cycle.

Reset
REQ-029 rst_n low at a clock edge SHALL force IDLE and the round-robin pointer to RR_INIT.
REQ-030 Reset SHALL drive all outputs to 0.
REQ-031 An in-flight request SHALL be dropped on reset with no response.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the vlmul encodings (VLMUL_1/2/4/8) and the NUM_VREGS = 32 constant.
REQ-033 The 2-way round-robin arbiter SHALL be a sub-module named rr_arb2 (inputs: valids and pointer; outputs: one-hot grant).
REQ-034 The illegal-request check SHALL be combinational on the latched request.

Verification
REQ-035 req0 only, sel=8, vlmul=3, registers r8..r15 = 8..15 -> req0_ready in T, mux_sel=8 in T+1, rsp_valid in T+2, rsp_data = {15,...,8}, rsp_err=0.
REQ-036 Both valid continuously, rsp_ready=1, pointer=0 -> grants alternate 0,1,0,1, one every 3 cycles, rsp_id follows the grant.
REQ-037 req1 sel=5, vlmul=2 -> rsp_err=1, rsp_data=0; req1 sel=4, vlmul=5 -> rsp_err=1.
REQ-038 rsp_ready held low for 4 cycles -> rsp_valid/data stable, both reqN_ready low, no new grant until the cycle after rsp_ready=1.
REQ-039 rst_n low during READ -> next cycle IDLE, all outputs 0, no response for the dropped request, first grant goes to RR_INIT.
REQ-040 vlmul=0, sel=31, r31=0xDEADBEEF -> rsp_data = 224'b0 followed by 0xDEADBEEF, rsp_err=0.
